// File: rtl/strip_pkg.sv
// Shared definitions for the strip frame writer: state encoding, word geometry,
// and pixel field offsets inside each 20-bit strip pixel.
package strip_pkg;

   // FILL collects bytes, WRITE strobes the buffer, CSUM checks the trailer
   // (checksum builds only), FULL holds the frame until the serialiser takes it.
   typedef enum logic [1:0] {
      StFill  = 2'd0,
      StWrite = 2'd1,
      StCsum  = 2'd2,
      StFull  = 2'd3
   } state_e;

   localparam int unsigned WORD_W         = 80;
   localparam int unsigned PIXEL_W        = 20;
   localparam int unsigned BYTES_PER_WORD = 10;
   localparam int unsigned FRAME_WORDS    = 128;

   // Pixel layout {R[6:0], G[6:0], B[5:0]}
   localparam int unsigned R_MSB = 19;
   localparam int unsigned R_LSB = 13;
   localparam int unsigned G_MSB = 12;
   localparam int unsigned G_LSB = 6;
   localparam int unsigned B_MSB = 5;
   localparam int unsigned B_LSB = 0;

endpackage

// File: rtl/byte_packer.sv
// Shifts host bytes into an 80-bit word, first byte ending up in the top byte.
// word_done_o flags the handshake that completes a word.
module byte_packer
   import strip_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [7:0]        data_i,
   output logic [3:0]        byte_idx_o,
   output logic [WORD_W-1:0] word_o,
   output logic              word_done_o
);

   logic [3:0]        idx_q;
   logic [WORD_W-1:0] word_q;

   assign word_done_o = en_i && (idx_q == 4'(BYTES_PER_WORD - 1));

   // Byte index: abandoned words restart at byte 0.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         idx_q <= '0;
      end else if (en_i) begin
         idx_q <= word_done_o ? 4'd0 : idx_q + 4'd1;
      end
   end

   // Shift register: after ten shifts byte 0 sits in [79:72].
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word_q <= '0;
      end else if (en_i) begin
         word_q <= {word_q[WORD_W-9:0], data_i};
      end
   end

   assign byte_idx_o = idx_q;
   assign word_o     = word_q;

endmodule

// File: rtl/counter.sv
// Generic up-counter: synchronous clear has priority over enable; wraps at 2^WIDTH.
module counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] out_o
);

   logic [WIDTH-1:0] count_q;

   // Count register with clear taking precedence.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign out_o = count_q;

endmodule

// File: rtl/strip_frame_writer.sv
// Packs the host byte stream into 80-bit strip words and fills the frame buffer.
// Partial frames are dropped after an inter-byte timeout.
// Build option: FRAME_CHECKSUM_EN adds a trailing XOR checksum byte per frame.
module strip_frame_writer
   import strip_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 5000,
   parameter int unsigned WORDS          = FRAME_WORDS,
   localparam int unsigned AddrW         = $clog2(WORDS)
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [AddrW-1:0]  wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              wr_en,
   output logic              frame_full,
   input  logic              frame_taken,
   output logic              frame_drop
);

   localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);

   state_e            state_q, state_d;
   logic [3:0]        byte_idx;
   logic              word_done;
   logic [TimerW-1:0] timer;
   logic              accept, fill_byte, idle, timing, timeout, csum_bad, drop;
   logic              last_word, addr_clr, timer_clr;
   logic              frame_drop_q;

   assign accept    = in_valid && in_ready;
   assign fill_byte = accept && (state_q == StFill);
   // No frame in progress: nothing to time out, nothing to discard.
   assign idle      = (state_q == StFill) && (byte_idx == 4'd0) && (wr_addr == '0);
   assign timing    = (state_q == StFill) || (state_q == StCsum);
   assign timeout   = timing && !idle && (timer == TimerW'(TIMEOUT_CYCLES - 1));
   assign last_word = (wr_addr == AddrW'(WORDS - 1));
   assign drop      = timeout || csum_bad;

   // Input is refused in the timeout cycle so no byte lands in a discarded frame.
   assign in_ready   = timing && !timeout;
   assign wr_en      = (state_q == StWrite);
   assign frame_full = (state_q == StFull);
   assign frame_drop = frame_drop_q;

   assign addr_clr  = rst || drop || (wr_en && last_word);
   assign timer_clr = rst || accept || idle || timeout;

`ifdef FRAME_CHECKSUM_EN
   logic [7:0] xor_q;

   // Running XOR of data bytes; the first byte of a frame restarts it.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         xor_q <= '0;
      end else if (fill_byte) begin
         xor_q <= idle ? in_data : (xor_q ^ in_data);
      end
   end

   assign csum_bad = (state_q == StCsum) && accept && (in_data != xor_q);
`else
   assign csum_bad = 1'b0;
`endif

   byte_packer u_packer (
      .clk_i       (sys_clk),
      .rst_i       (rst),
      .clr_i       (drop),
      .en_i        (fill_byte),
      .data_i      (in_data),
      .byte_idx_o  (byte_idx),
      .word_o      (wr_data),
      .word_done_o (word_done)
   );

   counter #(
      .WIDTH (AddrW)
   ) u_addr_cnt (
      .clk_i (sys_clk),
      .rst_i (addr_clr),
      .en_i  (wr_en),
      .out_o (wr_addr)
   );

   counter #(
      .WIDTH (TimerW)
   ) u_timer_cnt (
      .clk_i (sys_clk),
      .rst_i (timer_clr),
      .en_i  (timing),
      .out_o (timer)
   );

   // State and drop-pulse registers.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q      <= StFill;
         frame_drop_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_drop_q <= drop;
      end
   end

   // Next-state logic; frame_taken only matters in FULL.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFill: begin
            if (timeout) begin
               state_d = StFill;
            end else if (word_done) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (last_word) begin
`ifdef FRAME_CHECKSUM_EN
               state_d = StCsum;
`else
               state_d = StFull;
`endif
            end else begin
               state_d = StFill;
            end
         end
         StCsum: begin
            if (timeout || csum_bad) begin
               state_d = StFill;
            end else if (accept) begin
               state_d = StFull;
            end
         end
         StFull: begin
            if (frame_taken) begin
               state_d = StFill;
            end
         end
         default: state_d = StFill;
      endcase
   end

endmodule
